// File: rtl/ram_regfile_pkg.sv
// Shared types and helpers for the wait-state register file / memory slave.
// Used by the decoder and the top-level FSM.
package ram_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        DEC_REG,
        DEC_MEM,
        DEC_ERR
    } decode_t;

    // Byte-lane merge, parameterised by bus width.
    class merge_c #(int W = 32);
        static function logic [W-1:0] merge_bytes(
            input logic [W-1:0]   old_w,
            input logic [W-1:0]   new_w,
            input logic [W/8-1:0] strb
        );
            logic [W-1:0] r;
            r = old_w;
            for (int k = 0; k < W/8; k++) begin
                if (strb[k]) r[8*k +: 8] = new_w[8*k +: 8];
            end
            return r;
        endfunction
    endclass

endpackage

// File: rtl/ram_regfile_decode.sv
// Combinational byte-address decoder: register slot, memory word or error.
// Shared with the multi-port variant.
module ram_regfile_decode
    import ram_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_REGS   = 16,
    parameter int REG_STRIDE = 64,
    parameter int MEM_BASE   = 'h0400,
    parameter int MEM_BYTES  = 2048,
    parameter int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    parameter int MW = (MEM_BYTES*8/DATA_WIDTH > 1) ?
                       $clog2(MEM_BYTES*8/DATA_WIDTH) : 1
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output decode_t               dec,
    output logic [RW-1:0]         reg_idx,
    output logic [MW-1:0]         mem_idx
);

    localparam int BPW      = DATA_WIDTH / 8;
    localparam int REG_SPAN = NUM_REGS * REG_STRIDE;

    logic [31:0] a;
    logic        aligned;
    logic        reg_hit;
    logic        mem_hit;

    always_comb begin
        a       = 32'(addr);
        aligned = (a % BPW) == 0;
        reg_hit = aligned && (a < REG_SPAN) && ((a % REG_STRIDE) == 0);
        mem_hit = aligned && (a >= MEM_BASE) && (a < MEM_BASE + MEM_BYTES);
        reg_idx = RW'(a / REG_STRIDE);
        mem_idx = MW'((a - MEM_BASE) / BPW);
        dec     = DEC_ERR;
        // Regions never overlap, so the two hits are exclusive.
        unique case (1'b1)
            reg_hit: dec = DEC_REG;
            mem_hit: dec = DEC_MEM;
            default: dec = DEC_ERR;
        endcase
    end

endmodule

// File: rtl/ram_regfile_ws.sv
// Register file plus word memory slave with wait states, read-only
// registers and an error response on illegal accesses.
module ram_regfile_ws
    import ram_regfile_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    NUM_REGS    = 16,
    parameter int                    REG_STRIDE  = 64,
    parameter int                    MEM_BASE    = 'h0400,
    parameter int                    MEM_BYTES   = 2048,
    parameter int                    WAIT_STATES = 0,
    parameter logic [31:0]           RO_MASK     = 32'h0001,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA0B1_0002
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    err
);

    localparam int BPW   = DATA_WIDTH / 8;
    localparam int WORDS = MEM_BYTES / BPW;
    localparam int RW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int MW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    if (NUM_REGS > 32) begin : g_chk_regs
        $error("NUM_REGS must not exceed 32");
    end
    if (NUM_REGS < 32 && (RO_MASK >> NUM_REGS) != 0) begin : g_chk_mask
        $error("RO_MASK is wider than NUM_REGS");
    end
    if (MEM_BASE < NUM_REGS * REG_STRIDE) begin : g_chk_overlap
        $error("memory region overlaps register region");
    end
    if (DATA_WIDTH % 8 != 0 || WAIT_STATES > 15) begin : g_chk_misc
        $error("bad DATA_WIDTH or WAIT_STATES");
    end

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   din_q;
    logic [BPW-1:0]          strb_q;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]   mem  [WORDS];

    decode_t                 dec;
    logic [RW-1:0]           reg_idx;
    logic [MW-1:0]           mem_idx;
    logic                    exec;
    logic                    reg_wr;
    logic                    mem_wr;
    logic                    rsp_err;
    logic [DATA_WIDTH-1:0]   rsp_data;

    ram_regfile_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .REG_STRIDE (REG_STRIDE),
        .MEM_BASE   (MEM_BASE),
        .MEM_BYTES  (MEM_BYTES),
        .RW         (RW),
        .MW         (MW)
    ) u_decode (
        .addr    (addr_q),
        .dec     (dec),
        .reg_idx (reg_idx),
        .mem_idx (mem_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (enable) state_d = BUSY;
            BUSY: begin
                if (!enable)           state_d = IDLE;
                else if (cnt_q == '0)  state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset wins over a completing access so in-flight writes are dropped.
    always_comb begin
        exec     = rst_n && (state_q == BUSY) && enable && (cnt_q == '0);
        rsp_err  = 1'b1;
        rsp_data = '0;
        reg_wr   = 1'b0;
        mem_wr   = 1'b0;
        unique case (dec)
            DEC_REG: begin
                if (!we_q) begin
                    rsp_err  = 1'b0;
                    rsp_data = regs[reg_idx];
                end else if (!RO_MASK[reg_idx]) begin
                    rsp_err = 1'b0;
                    reg_wr  = exec;
                end
            end
            DEC_MEM: begin
                rsp_err = 1'b0;
                mem_wr  = exec && we_q;
                if (!we_q) rsp_data = mem[mem_idx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            ready  <= 1'b0;
            err    <= 1'b0;
            dout   <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            strb_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == 0 && RO_MASK[0]) ? ID_VALUE : '0;
            end
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            dout  <= '0;
            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        we_q   <= we;
                        addr_q <= addr;
                        din_q  <= din;
                        strb_q <= strb;
                        cnt_q  <= 4'(WAIT_STATES);
                    end
                end
                BUSY: begin
                    if (enable && cnt_q != '0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (exec) begin
                        ready <= 1'b1;
                        err   <= rsp_err;
                        dout  <= rsp_data;
                    end
                end
                default: ;
            endcase
            if (reg_wr) begin
                regs[reg_idx] <= merge_c#(DATA_WIDTH)::merge_bytes(
                    regs[reg_idx], din_q, strb_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_idx] <= merge_c#(DATA_WIDTH)::merge_bytes(
                mem[mem_idx], din_q, strb_q);
        end
    end

endmodule

// File: tb/tb_ram_regfile_ws.sv
// Directed and random checks of ram_regfile_ws at three wait-state settings
// against a behavioural model of registers and memory.
module tb_ram_regfile_ws;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  [3];
    logic        enable [3];
    logic        we     [3];
    logic [15:0] addr   [3];
    logic [31:0] din    [3];
    logic [3:0]  strb   [3];
    logic        ready  [3];
    logic [31:0] dout   [3];
    logic        err    [3];

    int checks = 0;
    int errors = 0;

    localparam int WS [3] = '{0, 3, 2};
    localparam logic [31:0] ID = 32'hA0B1_0002;

    ram_regfile_ws #(.WAIT_STATES(0)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .enable(enable[0]), .we(we[0]),
        .addr(addr[0]), .din(din[0]), .strb(strb[0]),
        .ready(ready[0]), .dout(dout[0]), .err(err[0]));
    ram_regfile_ws #(.WAIT_STATES(3)) u1 (
        .clk(clk), .rst_n(rst_n[1]), .enable(enable[1]), .we(we[1]),
        .addr(addr[1]), .din(din[1]), .strb(strb[1]),
        .ready(ready[1]), .dout(dout[1]), .err(err[1]));
    ram_regfile_ws #(.WAIT_STATES(2)) u2 (
        .clk(clk), .rst_n(rst_n[2]), .enable(enable[2]), .we(we[2]),
        .addr(addr[2]), .din(din[2]), .strb(strb[2]),
        .ready(ready[2]), .dout(dout[2]), .err(err[2]));

    // Reference model: register contents per DUT, memory keyed by dut/address.
    logic [31:0] mreg [3][16];
    logic [31:0] mmem [int];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0]  s);
        logic [31:0] r = o;
        for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    task automatic model_reset(input int d);
        for (int i = 0; i < 16; i++) mreg[d][i] = (i == 0) ? ID : 32'h0;
    endtask

    task automatic model(input int d, input bit w, input int a,
                         input logic [31:0] di, input logic [3:0] s,
                         output bit e, output logic [31:0] r, output bit k);
        int key;
        int i;
        e = 1'b1;
        r = 32'h0;
        k = 1'b1;
        if (a % 4 != 0) begin
            e = 1'b1;
        end else if (a < 16*64 && a % 64 == 0) begin
            i = a / 64;
            e = w && (i == 0);
            if (!w)         r = mreg[d][i];
            else if (i != 0) mreg[d][i] = mrg(mreg[d][i], di, s);
        end else if (a >= 'h400 && a < 'h400 + 2048) begin
            key = d * 65536 + a;
            e = 1'b0;
            if (w)                     mmem[key] = mrg(mmem.exists(key) ? mmem[key] : 32'h0, di, s);
            else if (mmem.exists(key)) r = mmem[key];
            else                       k = 1'b0;
        end
    endtask

    task automatic run(input int d, input bit w, input int a,
                       input logic [31:0] di, input logic [3:0] s,
                       input int lat, input bit hold, input string tag);
        int n;
        bit e;
        bit k;
        logic [31:0] r;
        @(negedge clk);
        enable[d] = 1'b1;
        we[d]     = w;
        addr[d]   = 16'(a);
        din[d]    = di;
        strb[d]   = s;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready[d] && n < 40);
        chk({tag, ".lat"}, 32'(n), 32'(lat));
        model(d, w, a, di, s, e, r, k);
        if (ready[d]) begin
            chk({tag, ".err"}, 32'(err[d]), 32'(e));
            if (!w && k) chk({tag, ".dout"}, dout[d], r);
        end
        if (!hold) begin
            @(negedge clk);
            enable[d] = 1'b0;
            @(posedge clk);
            #1;
            chk({tag, ".pulse"}, 32'(ready[d]), 32'h0);
        end
    endtask

    initial begin
        int cnt;
        int kind;
        int a;
        int key;
        bit w;
        logic [3:0] s;

        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; enable[d] = 1'b0; we[d] = 1'b0;
            addr[d] = '0; din[d] = '0; strb[d] = '0;
            model_reset(d);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst.ready", 32'(ready[d]), 32'h0);
            chk("rst.err", 32'(err[d]), 32'h0);
            chk("rst.dout", dout[d], 32'h0);
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

        run(0, 0, 'h0000, 0, 4'hF, 2, 0, "id_read");
        run(0, 0, 'h0040, 0, 4'hF, 2, 0, "reg1_read");

        run(1, 1, 'h0040, 32'hDEAD_BEEF, 4'b0101, 5, 0, "ws3_write");
        run(1, 0, 'h0040, 0, 4'hF, 5, 0, "ws3_readback");

        run(0, 1, 'h0000, 32'h1234_5678, 4'hF, 2, 0, "ro_write");
        run(0, 0, 'h0000, 0, 4'hF, 2, 0, "ro_readback");
        run(0, 1, 'h0042, 32'h1111_1111, 4'hF, 2, 0, "misaligned");
        run(0, 0, 'h0044, 0, 4'hF, 2, 0, "gap_read");
        run(0, 1, 'h00C0, 32'h5555_5555, 4'h0, 2, 0, "strb0_write");
        run(0, 0, 'h00C0, 0, 4'hF, 2, 0, "strb0_read");

        run(0, 1, 'h0400, 32'hCAFE_F00D, 4'hF, 2, 0, "mem_lo_wr");
        run(0, 1, 'h0BFC, 32'h0000_0001, 4'hF, 2, 0, "mem_hi_wr");
        run(0, 0, 'h0400, 0, 4'hF, 2, 0, "mem_lo_rd");
        run(0, 0, 'h0BFC, 0, 4'hF, 2, 0, "mem_hi_rd");
        run(0, 0, 'h0C00, 0, 4'hF, 2, 0, "mem_past_end");

        run(2, 1, 'h0400, 32'hAAAA_5555, 4'hF, 4, 0, "abort_pre");
        @(negedge clk);
        enable[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0400;
        din[2] = 32'hBAD0_BAD0; strb[2] = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        enable[2] = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (ready[2]) cnt++;
        end
        chk("abort.no_ready", 32'(cnt), 32'h0);
        run(2, 0, 'h0400, 0, 4'hF, 4, 0, "abort_readback");

        run(2, 1, 'h0404, 32'h1122_3344, 4'hF, 4, 0, "rstbusy_pre");
        @(negedge clk);
        enable[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0404;
        din[2] = 32'hFFFF_FFFF; strb[2] = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n[2] = 1'b0;
        @(posedge clk);
        #1;
        chk("rstbusy.ready", 32'(ready[2]), 32'h0);
        chk("rstbusy.err", 32'(err[2]), 32'h0);
        @(negedge clk);
        enable[2] = 1'b0;
        rst_n[2] = 1'b1;
        model_reset(2);
        run(2, 0, 'h0404, 0, 4'hF, 4, 0, "rstbusy_readback");

        run(0, 1, 'h0080, 32'h0BAD_CAFE, 4'hF, 2, 1, "b2b_write");
        run(0, 0, 'h0080, 0, 4'hF, 3, 0, "b2b_read");

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 4);
            w = 1'($urandom_range(0, 1));
            s = 4'($urandom_range(0, 15));
            unique case (kind)
                0: a = 64 * $urandom_range(0, 15);
                1: a = 'h400 + 4 * (($urandom_range(0, 1) == 1) ?
                        $urandom_range(508, 511) : $urandom_range(0, 3));
                2: a = 64 * $urandom_range(0, 15) + $urandom_range(1, 3);
                3: a = 64 * $urandom_range(0, 15) + 4 * $urandom_range(1, 15);
                default: a = 'h0C00 + 4 * $urandom_range(0, 255);
            endcase
            key = a;
            if (kind == 1 && w && !mmem.exists(key)) s = 4'hF;
            run(0, w, a, $urandom, s, 2, 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
